program_loader: RTL
===================

# program_loader

Boot-time writer for the unified instruction/data RAM. It receives a framed program image as a byte stream over a valid/ready handshake. It assembles little-endian 32-bit words and drives them into the RAM's write port, holding the pipeline stalled until the image is fully written and its checksum has been verified. It sits between the host byte link (e.g. a UART receiver) and the data-memory write port, and is muxed onto that port only while loading.

## Interface
Parameters:
- `DEPTH`, 128: number of RAM words; the image word count must not exceed it.
- `ADDR_WIDTH`, 7: RAM word-address width, equal to clog2(DEPTH).

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous and active-low.
- `rx_valid`  in  1: byte on `rx_data` is valid.
- `rx_data`  in  8: stream byte.
- `rx_ready`  out  1: loader can accept a byte.
- `mem_write_enable`  out  1: one-cycle write strobe to the RAM.
- `mem_write_address`  out  ADDR_WIDTH: RAM word address.
- `mem_write_data`  out  OPERAND_WIDTH: word to write.
- `cpu_stall`  out  1: holds fetch/pipeline stalled while high.
- `load_done`  out  1: image written and checksum OK; sticky.
- `load_error`  out  1: oversize count or checksum mismatch; sticky.

## Operation
- Frame format:
  - count_lo, count_hi: 16-bit word count N, little-endian.
  - N×4 payload bytes, each word little-endian (first byte goes to bits 7:0).
  - One checksum byte: the 8-bit wraparound sum of all preceding frame bytes, including the count bytes.
- Byte transfer: a byte is accepted on a rising edge where `rx_valid && rx_ready`. Nothing else advances state.
- States (enum `loader_state_t`):
  - COUNT_LO: latch low count byte → COUNT_HI.
  - COUNT_HI: latch high byte. N > DEPTH → ERROR. N == 0 → CHECKSUM. Otherwise → PAYLOAD.
  - PAYLOAD: shift bytes into the word assembler. On the 4th byte of a word, register the write. After word N−1 completes → CHECKSUM.
  - CHECKSUM: accepted byte equals the running sum → DONE. Otherwise → ERROR.
  - DONE / ERROR: terminal. Leaving either state requires `rst` low.
- `rx_ready` is 1 in COUNT_LO, COUNT_HI, PAYLOAD and CHECKSUM, and 0 in DONE and ERROR.
- Writes:
  - `mem_write_address` = word index, counting from 0 and truncated to ADDR_WIDTH. Because N ≤ DEPTH is enforced, the index never wraps.
  - Words are written even if the checksum later fails. `load_error` tells the system not to run the image.
- Running sum is 8-bit modulo arithmetic, updated on every accepted byte except the checksum byte itself.
- Outputs by state:
  - `cpu_stall` = 1 in every state except DONE.
  - ERROR keeps `cpu_stall` = 1.
- Reset mid-frame discards the partial word, count, sum and index, and returns to COUNT_LO. RAM contents are left as written.

## Timing
- Reset values:
  - state = COUNT_LO, `rx_ready` = 1, `mem_write_enable` = 0.
  - `mem_write_address` = 0, `mem_write_data` = 0.
  - `cpu_stall` = 1, `load_done` = 0, `load_error` = 0.
- Write latency: `mem_write_enable` is high for exactly one cycle, in the cycle after the edge that accepted the 4th byte of a word. Address and data are stable during that cycle.
- Back-to-back bytes every cycle are supported. The write strobe of word k may coincide with acceptance of byte 0 of word k+1.
- Status update: `load_done` or `load_error` rises, and `cpu_stall` falls on success, in the cycle after the edge that accepted the checksum byte.
  - The final data write always precedes `load_done` by at least one cycle.
- ERROR on oversize count is entered on the edge that accepts count_hi. No writes occur.
- `rx_valid` low in mid-word stalls assembly indefinitely; no timeout.

## Structure
- New package `program_loader_params` holds:
  - `loader_state_t`;
  - `DEFAULT_DEPTH`, `DEFAULT_ADDR_WIDTH`;
  - `COUNT_WIDTH` = 16.
- `OPERAND_WIDTH` comes from `register_file_params`.
- One sub-module, `word_assembler`: a 2-bit byte index and 32-bit shift register with a `word_valid` pulse. It is cleared by reset and by the FSM on entry to PAYLOAD.
- FSM, counters, running sum and output registers live in `program_loader`. Estimated size is about 200 lines.

## Test plan
- N=1, payload 0x78 0x56 0x34 0x12, checksum 0x15 → one write of addr 0, data 0x12345678. `load_done`=1, `cpu_stall`=0 one cycle after the checksum is accepted.
- N=2 streamed with `rx_valid` held high → writes at addr 0 and 1, each a single-cycle strobe. The second strobe is ≥1 cycle before `load_done`.
- Count 0x0081 (129 > 128) → `load_error`=1 after count_hi, `rx_ready`=0, no `mem_write_enable`, `cpu_stall` stays 1.
- N=1 with checksum off by one → the word is still written, then `load_error`=1, `load_done`=0, `cpu_stall`=1.
- N=0, checksum 0x00 → DONE with no writes.
- Reset asserted after 2 payload bytes, then a full N=1 frame → a single write with data from the new frame only, then `load_done`=1. Random `rx_valid` gaps must not change the result.

Source files
------------

// File: rtl/program_loader_pkg.sv
// Shared parameters for the boot loader slice: operand width from the register file
// and the loader's state encoding, default geometry and frame count width.
package register_file_params;
  localparam int OPERAND_WIDTH = 32;
endpackage

package program_loader_params;
  localparam int DEFAULT_DEPTH      = 128;
  localparam int DEFAULT_ADDR_WIDTH = 7;
  localparam int COUNT_WIDTH        = 16;

  typedef enum logic [2:0] {
    COUNT_LO,
    COUNT_HI,
    PAYLOAD,
    CHECKSUM,
    DONE,
    ERROR
  } loader_state_t;
endpackage

// File: rtl/program_loader_word_assembler.sv
// Collects four stream bytes into a little-endian word; word_valid flags the
// fourth byte combinationally so the caller can register the write one cycle later.
module word_assembler
  import register_file_params::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic [OPERAND_WIDTH-1:0] word_data,
  output logic                     word_valid
);
  logic [1:0]               byte_index_reg;
  logic [OPERAND_WIDTH-1:0] shift_reg;

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      byte_index_reg <= '0;
      shift_reg      <= '0;
    end else if (byte_valid) begin
      byte_index_reg <= byte_index_reg + 2'd1;
      shift_reg      <= {byte_data, shift_reg[OPERAND_WIDTH-1:8]};
    end
  end

  // The incoming fourth byte completes the word without waiting for the shift.
  assign word_data  = {byte_data, shift_reg[OPERAND_WIDTH-1:8]};
  assign word_valid = byte_valid && (byte_index_reg == 2'd3);
endmodule

// File: rtl/program_loader.sv
// Boot-time loader: parses a counted, checksummed byte frame and writes the
// assembled words into the unified RAM while holding the CPU stalled.
module program_loader
  import register_file_params::*;
  import program_loader_params::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     rx_ready,
  output logic                     mem_write_enable,
  output logic [ADDR_WIDTH-1:0]    mem_write_address,
  output logic [OPERAND_WIDTH-1:0] mem_write_data,
  output logic                     cpu_stall,
  output logic                     load_done,
  output logic                     load_error
);
  loader_state_t state_reg, state_next;

  logic [COUNT_WIDTH-1:0]   count_reg;
  logic [COUNT_WIDTH-1:0]   word_index_reg;
  logic [7:0]               sum_reg;
  logic                     we_reg;
  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [OPERAND_WIDTH-1:0] data_reg;

  logic                     accept;
  logic [COUNT_WIDTH-1:0]   count_full;
  logic [OPERAND_WIDTH-1:0] word_data;
  logic                     word_valid;

  assign accept     = rx_valid && rx_ready;
  assign count_full = {rx_data, count_reg[7:0]};

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (accept && (state_reg == COUNT_HI)),
    .byte_valid (accept && (state_reg == PAYLOAD)),
    .byte_data  (rx_data),
    .word_data  (word_data),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= COUNT_LO;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      COUNT_LO: if (accept) state_next = COUNT_HI;
      COUNT_HI: begin
        if (accept) begin
          if (count_full > COUNT_WIDTH'(DEPTH)) state_next = ERROR;
          else if (count_full == '0)            state_next = CHECKSUM;
          else                                  state_next = PAYLOAD;
        end
      end
      PAYLOAD:  if (word_valid && (word_index_reg == count_reg - 16'd1)) state_next = CHECKSUM;
      CHECKSUM: if (accept) state_next = (rx_data == sum_reg) ? DONE : ERROR;
      default:  state_next = state_reg;
    endcase
  end

  always_comb begin
    rx_ready   = (state_reg != DONE) && (state_reg != ERROR);
    cpu_stall  = (state_reg != DONE);
    load_done  = (state_reg == DONE);
    load_error = (state_reg == ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg      <= '0;
      word_index_reg <= '0;
      sum_reg        <= '0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
    end else begin
      we_reg <= word_valid;
      if (word_valid) begin
        addr_reg       <= word_index_reg[ADDR_WIDTH-1:0];
        data_reg       <= word_data;
        word_index_reg <= word_index_reg + 16'd1;
      end
      // The checksum byte itself is excluded from the running sum.
      if (accept && (state_reg != CHECKSUM)) sum_reg <= sum_reg + rx_data;
      if (accept && (state_reg == COUNT_LO)) count_reg[7:0]  <= rx_data;
      if (accept && (state_reg == COUNT_HI)) count_reg[15:8] <= rx_data;
    end
  end

  assign mem_write_enable  = we_reg;
  assign mem_write_address = addr_reg;
  assign mem_write_data    = data_reg;
endmodule
